// File: rtl/ravenna_uart_rx.sv
// Ravenna UART receiver: 8N1 mid-bit sampling with a small byte FIFO.
// Define RAVENNA_UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module ravenna_uart_rx #(
  parameter int unsigned DIV_WIDTH = 16,
  parameter int unsigned FIFO_AW   = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [DIV_WIDTH-1:0] cfg_divider,
  input  logic                 ser_rx,
  input  logic                 rd_en,
  output logic                 rd_valid,
  output logic [7:0]           rd_data,
  input  logic                 err_clr,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

  state_t               state, state_n;
  logic [DIV_WIDTH-1:0] cnt, cnt_n;
  logic [2:0]           idx, idx_n;
  logic [7:0]           shreg, shreg_n;
  logic                 rx_meta, rx_s, rx_prev;
  logic                 push_req, ferr_set, perr_set;
  logic [DIV_WIDTH-1:0] period;
  logic                 fire, fall;

  // Synchroniser plus one delay flop for start-edge detection; idle level is 1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= ser_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign period = (cfg_divider < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : cfg_divider;
  assign fire   = (cnt == DIV_WIDTH'(1));
  assign fall   = rx_prev & ~rx_s;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = (cnt > DIV_WIDTH'(1)) ? cnt - DIV_WIDTH'(1) : cnt;
    idx_n    = idx;
    shreg_n  = shreg;
    push_req = 1'b0;
    ferr_set = 1'b0;
    perr_set = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          cnt_n   = period >> 1;
          state_n = START;
        end
      end
      START: begin
        if (fire) begin
          if (!rx_s) begin
            state_n = DATA;
            cnt_n   = period;
            idx_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        if (fire) begin
          shreg_n[idx] = rx_s;
          cnt_n        = period;
          if (idx == 3'd7) begin
`ifdef RAVENNA_UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
`ifdef RAVENNA_UART_RX_PARITY_EN
      PARITY: begin
        if (fire) begin
          perr_set = rx_s ^ (^shreg);
          cnt_n    = period;
          state_n  = STOP;
        end
      end
`endif
      STOP: begin
        if (fire) begin
          if (rx_s) begin
            push_req = 1'b1;
            state_n  = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_n  = BRK;
          end
        end
      end
      BRK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [FIFO_AW:0]   count;
  logic             full, pop, push;

  assign full     = (count == (FIFO_AW+1)'(DEPTH));
  assign rd_valid = (count != '0);
  assign rd_data  = rd_valid ? mem[rptr] : '0;
  assign pop      = rd_en & rd_valid;
  // A full FIFO still accepts the byte when the head is popped in the same cycle.
  assign push     = push_req & (~full | pop);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= shreg;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + FIFO_AW'(1);
      if (pop)  rptr <= rptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (ferr_set)     frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (push_req & full & ~pop) overrun <= 1'b1;
      else if (err_clr)           overrun <= 1'b0;
    end
  end

`ifdef RAVENNA_UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      parity_err <= 1'b0;
    else if (perr_set) parity_err <= 1'b1;
    else if (err_clr)  parity_err <= 1'b0;
  end
`else
  assign parity_err = 1'b0;
  logic unused_perr;
  assign unused_perr = perr_set;
`endif

endmodule
